paddle_motion_ctrl: RTL and testbench

Parametrised successor to the current paddle controller, with acceleration, clamped travel along a configurable axis, and a common motion engine for player and AI. Sits between the input/AI logic and the renderer/collision logic. It takes mode, button, and AI-target inputs and produces a registered paddle position plus status flags. Geometry, clock rate, and speed profile are all generics, so the same block serves both paddles, horizontal or vertical.

---
 rtl/paddle_motion_ctrl.sv | 155 +++++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion_ctrl.sv
// Paddle motion engine: decodes manual/AI commands and steps a clamped, accelerating position.
// Define PADDLE_ACCEL_EN for multi-level acceleration; otherwise every step uses the level-0 period.
module paddle_motion_ctrl #(
  parameter int POS_W       = 10,
  parameter int AXIS_LEN    = 480,
  parameter int PDL_LEN     = 96,
  parameter int CLK_HZ      = 25_175_000,
  parameter int MIN_SPEED   = 300,
  parameter int MAX_SPEED   = 900,
  parameter int ACCEL_STEPS = 4,
  parameter int STEP_HOLD   = 8,
  parameter int AI_DEADBAND = 2
) (
  input  logic             clk_0,
  input  logic             rst,
  input  logic             reset_game,
  input  logic [1:0]       mode_choice,
  input  logic             move_up,
  input  logic             move_down,
  input  logic [POS_W-1:0] ai_target,
  output logic [POS_W-1:0] y_pos,
  output logic [2:0]       speed_lvl,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int YMAX   = AXIS_LEN - PDL_LEN;
  localparam int CENTRE = (AXIS_LEN - PDL_LEN) / 2;

  function automatic int psc_of(input int l);
    if (ACCEL_STEPS <= 1) return CLK_HZ / MIN_SPEED;
    return CLK_HZ / (MIN_SPEED + l * (MAX_SPEED - MIN_SPEED) / (ACCEL_STEPS - 1));
  endfunction

  localparam int PSC_TAB [8] = '{psc_of(0), psc_of(1), psc_of(2), psc_of(3),
                                 psc_of(4), psc_of(5), psc_of(6), psc_of(7)};
  localparam int CNT_W = $clog2(psc_of(0) + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] psc_q, psc_d, psc_lim;
  logic [2:0]       lvl_q, lvl_d;
  logic [1:0]       mode_q;
  logic             at_top_q, at_bot_q;
  logic             cmd_up, cmd_dn, mode_chg, still_cmd, pinned;
  logic [POS_W:0]   pos_w, tgt_w;

`ifdef PADDLE_ACCEL_EN
  localparam int SC_W = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
  logic [SC_W-1:0] sc_q, sc_d;
`else
  logic [31:0] unused_hold;
  assign unused_hold = STEP_HOLD;
`endif

  // AI comparison runs one bit wider so target + deadband cannot wrap.
  assign pos_w = {1'b0, y_q};
  assign tgt_w = {1'b0, ai_target};

  always_comb begin
    cmd_up = 1'b0;
    cmd_dn = 1'b0;
    case (mode_choice)
      2'b10: begin
        cmd_up = move_up & ~move_down;
        cmd_dn = move_down & ~move_up;
      end
      2'b01: begin
        cmd_up = pos_w > tgt_w + (POS_W+1)'(AI_DEADBAND);
        cmd_dn = tgt_w > pos_w + (POS_W+1)'(AI_DEADBAND);
      end
      default: ;
    endcase
  end

  assign mode_chg  = (mode_choice != mode_q);
  assign still_cmd = (state_q == MOVE_UP) ? cmd_up : cmd_dn;
  assign pinned    = (state_q == MOVE_UP) ? (y_q == '0) : (y_q == POS_W'(YMAX));
  assign psc_lim   = CNT_W'(PSC_TAB[lvl_q] - 1);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    psc_d   = psc_q;
    lvl_d   = lvl_q;
`ifdef PADDLE_ACCEL_EN
    sc_d    = sc_q;
`endif
    if (state_q == IDLE || mode_chg || !still_cmd) begin
      state_d = IDLE;
      psc_d   = '0;
      lvl_d   = '0;
`ifdef PADDLE_ACCEL_EN
      sc_d    = '0;
`endif
      if (state_q == IDLE && !mode_chg && (cmd_up || cmd_dn))
        state_d = cmd_up ? MOVE_UP : MOVE_DN;
    end else if (pinned) begin
      psc_d = '0;
      lvl_d = '0;
`ifdef PADDLE_ACCEL_EN
      sc_d  = '0;
`endif
    end else if (psc_q == psc_lim) begin
      psc_d = '0;
      y_d   = (state_q == MOVE_UP) ? y_q - 1'b1 : y_q + 1'b1;
`ifdef PADDLE_ACCEL_EN
      if (sc_q == SC_W'(STEP_HOLD - 1)) begin
        sc_d = '0;
        if (int'(lvl_q) < ACCEL_STEPS - 1) lvl_d = lvl_q + 1'b1;
      end else begin
        sc_d = sc_q + 1'b1;
      end
`endif
    end else begin
      psc_d = psc_q + 1'b1;
    end
`ifndef PADDLE_ACCEL_EN
    lvl_d = '0;
`endif
  end

  always_ff @(posedge clk_0) begin
    mode_q <= mode_choice;
    if (rst || reset_game) begin
      state_q  <= IDLE;
      y_q      <= POS_W'(CENTRE);
      psc_q    <= '0;
      lvl_q    <= '0;
      at_top_q <= (CENTRE == 0);
      at_bot_q <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      sc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      psc_q    <= psc_d;
      lvl_q    <= lvl_d;
      at_top_q <= (y_d == '0);
      at_bot_q <= (y_d == POS_W'(YMAX));
`ifdef PADDLE_ACCEL_EN
      sc_q     <= sc_d;
`endif
    end
  end

  assign y_pos     = y_q;
  assign speed_lvl = lvl_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bot_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Scoreboard bench for paddle_motion_ctrl: expected position changes are queued with their
// due cycle; a monitor compares every observed y_pos change against the queue head.
module tb_paddle_motion_ctrl;
  localparam int POS_W = 10;
  localparam int YMAX  = 32;

  logic             clk_0 = 1'b0;
  logic             rst, reset_game, move_up, move_down;
  logic [1:0]       mode_choice;
  logic [POS_W-1:0] ai_target, y_pos;
  logic [2:0]       speed_lvl;
  logic             at_top, at_bottom;

  paddle_motion_ctrl #(
    .POS_W(POS_W), .AXIS_LEN(40), .PDL_LEN(8), .CLK_HZ(1000), .MIN_SPEED(100),
    .MAX_SPEED(400), .ACCEL_STEPS(4), .STEP_HOLD(2), .AI_DEADBAND(2)
  ) dut (
    .clk_0(clk_0), .rst(rst), .reset_game(reset_game), .mode_choice(mode_choice),
    .move_up(move_up), .move_down(move_down), .ai_target(ai_target),
    .y_pos(y_pos), .speed_lvl(speed_lvl), .at_top(at_top), .at_bottom(at_bottom)
  );

  always #5 clk_0 = ~clk_0;

  int cyc = 0;
  always @(posedge clk_0) cyc <= cyc + 1;

  typedef struct {int c; int y; int l;} exp_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   prev_y;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-derived step schedule: PSC = 10/5/3/2, two steps per level.
  function automatic int gap(input int n);
`ifdef PADDLE_ACCEL_EN
    int psc [4] = '{10, 5, 3, 2};
    int l = (n - 1) / 2;
    if (l > 3) l = 3;
    return psc[l];
`else
    return 10 + 0 * n;
`endif
  endfunction

  function automatic int lvl_after(input int n);
`ifdef PADDLE_ACCEL_EN
    int l = n / 2;
    if (l > 3) l = 3;
    return l;
`else
    return 0 * n;
`endif
  endfunction

  function automatic int t_of(input int n);
    int s = 0;
    for (int k = 1; k <= n; k++) s += gap(k);
    return s;
  endfunction

  task automatic push_steps(input int em, input int y0, input int dir, input int n);
    for (int k = 1; k <= n; k++) q.push_back('{c: em + t_of(k), y: y0 + dir * k, l: lvl_after(k)});
  endtask

  always @(negedge clk_0) begin
    if (mon_en && int'(y_pos) != prev_y) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_move: got y_pos %0d at cycle %0d, expected no change from %0d",
                 y_pos, cyc, prev_y);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("step_cycle", cyc, e.c);
        check("step_y", int'(y_pos), e.y);
        check("step_lvl", int'(speed_lvl), e.l);
        check("step_at_top", int'(at_top), int'(e.y == 0));
        check("step_at_bottom", int'(at_bottom), int'(e.y == YMAX));
      end
    end
    prev_y = int'(y_pos);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_0);
  endtask

  task automatic drain(input string name, input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) @(negedge clk_0);
    check(name, q.size(), 0);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    q.push_back('{c: cyc + 1, y: 16, l: 0});
    tick(1);
    rst = 1'b0;
  endtask

  // Drive down from 16 to 25, then hit reset on the edge where step 10 is due.
  task automatic reset_on_step(input string name, input bit both, input int extra);
    int em;
    mode_choice = 2'b10;
    move_down   = 1'b1;
    em = cyc + 1 + extra;
    push_steps(em, 16, 1, 9);
    wait_cyc(em + t_of(10) - 1);
    check({name, "_pre_y"}, int'(y_pos), 25);
    reset_game = 1'b1;
    if (both) rst = 1'b1;
    q.push_back('{c: em + t_of(10), y: 16, l: 0});
    tick(1);
    reset_game = 1'b0;
    rst        = 1'b0;
    move_down  = 1'b0;
    check({name, "_lvl"}, int'(speed_lvl), 0);
    drain({name, "_drain"}, 20);
  endtask

  initial begin
    int em;
    rst = 1'b1; reset_game = 1'b0; move_up = 1'b0; move_down = 1'b0;
    mode_choice = 2'b00; ai_target = '0;
    tick(1);
    check("rst_y", int'(y_pos), 16);
    check("rst_lvl", int'(speed_lvl), 0);
    check("rst_at_top", int'(at_top), 0);
    check("rst_at_bottom", int'(at_bottom), 0);
    rst    = 1'b0;
    prev_y = int'(y_pos);
    mon_en = 1'b1;

    // Manual acceleration to the bottom limit; first edge absorbs the mode change.
    mode_choice = 2'b10;
    move_down   = 1'b1;
    em = cyc + 2;
    push_steps(em, 16, 1, 16);
    drain("accel_drain", 400);
    tick(10);
    check("pinned_y", int'(y_pos), YMAX);
    check("pinned_at_bottom", int'(at_bottom), 1);
    check("pinned_lvl", int'(speed_lvl), 0);
    move_down = 1'b0;

    // Both buttons: no motion.
    pulse_rst();
    move_up = 1'b1; move_down = 1'b1;
    tick(50);
    check("conflict_y", int'(y_pos), 16);
    check("conflict_lvl", int'(speed_lvl), 0);
    drain("conflict_drain", 5);
    move_up = 1'b0; move_down = 1'b0;

    // Reversal after four down steps.
    em = cyc + 1;
    move_down = 1'b1;
    push_steps(em, 16, 1, 4);
    wait_cyc(em + t_of(4));
    check("rev_pre_lvl", int'(speed_lvl), lvl_after(4));
    move_down = 1'b0; move_up = 1'b1;
    q.push_back('{c: em + t_of(4) + 12, y: 19, l: 0});
    tick(1);
    check("rev_idle_lvl", int'(speed_lvl), 0);
    drain("rev_drain", 40);
    move_up = 1'b0;

    // AI tracking toward 30, stopping at the deadband edge.
    pulse_rst();
    mode_choice = 2'b01;
    ai_target   = 10'd30;
    em = cyc + 2;
    push_steps(em, 16, 1, 12);
    drain("ai_drain", 300);
    tick(20);
    check("ai_stop_y", int'(y_pos), 28);
    ai_target = 10'd27;
    tick(30);
    check("ai_deadband_y", int'(y_pos), 28);
    check("ai_deadband_lvl", int'(speed_lvl), 0);

    // Reset during a due step.
    pulse_rst();
    reset_on_step("rgame", 1'b0, 1);
    reset_on_step("rboth", 1'b1, 0);

    tick(5);
    check("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected test completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
